// File: rtl/mem_arbiter19.sv
// mem_arbiter19: shares one single-port data memory between instruction fetch
// (IF), load/store (LS) and the FFT DMA port, with locked FFT bursts.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   if_req/if_addr -> if_gnt        IF read requests
//   ls_req/ls_we/ls_addr/ls_wdata   LS requests -> ls_gnt
//   fft_req/fft_we/fft_lock/...     FFT requests (optionally locked) -> fft_gnt
//   xx_rvalid, rdata                read data return, routed to the issuer
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  memory command and data
//   owner                           0 none, 1 IF, 2 LS, 3 FFT
// Build option: MEM_ARB_RR_EN selects round-robin arbitration (LS -> IF -> FFT)
// instead of fixed priority LS > IF > FFT.
module mem_arbiter19 #(
  parameter int unsigned AW        = 14,
  parameter int unsigned DW        = 19,
  parameter int unsigned MEM_LAT   = 1,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  output logic          ls_gnt,
  output logic          ls_rvalid,
  input  logic          fft_req,
  input  logic          fft_we,
  input  logic          fft_lock,
  input  logic [AW-1:0] fft_addr,
  input  logic [DW-1:0] fft_wdata,
  output logic          fft_gnt,
  output logic          fft_rvalid,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    owner
);

  localparam int unsigned CW = 8;
  localparam int unsigned NW = CW + 1;
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_LS   = 2'd2;
  localparam logic [1:0] OWN_FFT  = 2'd3;

  typedef enum logic {ST_ARB = 1'b0, ST_LOCKED = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NW-1:0] cnt_inc;
  logic          mask_q, mask_d;
  logic          fft_elig, arb_if, arb_ls, arb_fft;
  // One-hot read tags {fft, ls, if}; the last stage drives the rvalid outputs
  logic [2:0]    pipe_q [MEM_LAT];
  logic [2:0]    pipe_d [MEM_LAT];
  logic [2:0]    push;

`ifdef MEM_ARB_RR_EN
  localparam logic [1:0] RR_LS  = 2'd0;
  localparam logic [1:0] RR_IF  = 2'd1;
  localparam logic [1:0] RR_FFT = 2'd2;
  logic [1:0] rr_q, rr_d;
`endif

  // Normal arbitration; FFT is masked for one cycle after a forced release
  // only while a CPU-side requester is waiting.
  always_comb begin
    arb_if   = 1'b0;
    arb_ls   = 1'b0;
    arb_fft  = 1'b0;
    fft_elig = fft_req && !(mask_q && (if_req || ls_req));
`ifdef MEM_ARB_RR_EN
    // rr_q names the requester with highest priority this cycle
    case (rr_q)
      RR_IF: begin
        if (if_req)        arb_if  = 1'b1;
        else if (fft_elig) arb_fft = 1'b1;
        else if (ls_req)   arb_ls  = 1'b1;
      end
      RR_FFT: begin
        if (fft_elig)      arb_fft = 1'b1;
        else if (ls_req)   arb_ls  = 1'b1;
        else if (if_req)   arb_if  = 1'b1;
      end
      default: begin
        if (ls_req)        arb_ls  = 1'b1;
        else if (if_req)   arb_if  = 1'b1;
        else if (fft_elig) arb_fft = 1'b1;
      end
    endcase
`else
    if (ls_req)        arb_ls  = 1'b1;
    else if (if_req)   arb_if  = 1'b1;
    else if (fft_elig) arb_fft = 1'b1;
`endif
  end

  // Lock FSM: next state, burst count and grants
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = 1'b0;
    if_gnt  = 1'b0;
    ls_gnt  = 1'b0;
    fft_gnt = 1'b0;
    cnt_inc = NW'(cnt_q) + NW'(1);
    case (state_q)
      ST_ARB: begin
        if_gnt  = arb_if;
        ls_gnt  = arb_ls;
        fft_gnt = arb_fft;
        if (arb_fft && fft_lock) begin
          if (MAX_BURST <= 1) begin
            mask_d = 1'b1;
          end else begin
            state_d = ST_LOCKED;
            cnt_d   = CW'(1);
          end
        end
      end
      ST_LOCKED: begin
        if (!fft_lock) begin
          // Unlock: this cycle is arbitrated normally, no relock possible
          state_d = ST_ARB;
          cnt_d   = '0;
          if_gnt  = arb_if;
          ls_gnt  = arb_ls;
          fft_gnt = arb_fft;
        end else if (fft_req) begin
          fft_gnt = 1'b1;
          if (cnt_inc >= NW'(MAX_BURST)) begin
            // Forced release; relock needs a fresh grant in ARB
            state_d = ST_ARB;
            cnt_d   = '0;
            mask_d  = 1'b1;
          end else begin
            cnt_d = CW'(cnt_inc);
          end
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  // Memory command mux
  always_comb begin
    mem_en    = if_gnt | ls_gnt | fft_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    owner     = OWN_NONE;
    if (ls_gnt) begin
      mem_we    = ls_we;
      mem_addr  = ls_addr;
      mem_wdata = ls_wdata;
      owner     = OWN_LS;
    end else if (if_gnt) begin
      mem_addr  = if_addr;
      owner     = OWN_IF;
    end else if (fft_gnt) begin
      mem_we    = fft_we;
      mem_addr  = fft_addr;
      mem_wdata = fft_wdata;
      owner     = OWN_FFT;
    end
  end

  // Read tag shift pipeline
  always_comb begin
    push      = mem_we ? 3'b000 : {fft_gnt, ls_gnt, if_gnt};
    pipe_d[0] = push;
    for (int i = 1; i < MEM_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_ARB;
      cnt_q   <= '0;
      mask_q  <= 1'b0;
      for (int i = 0; i < MEM_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      pipe_q  <= pipe_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Pointer moves past the winner only on normally arbitrated grants
  always_comb begin
    rr_d = rr_q;
    if (state_q == ST_ARB || !fft_lock) begin
      if (ls_gnt)       rr_d = RR_IF;
      else if (if_gnt)  rr_d = RR_FFT;
      else if (fft_gnt) rr_d = RR_LS;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rr_q <= RR_LS;
    else       rr_q <= rr_d;
  end
`endif

  assign if_rvalid  = pipe_q[MEM_LAT-1][0];
  assign ls_rvalid  = pipe_q[MEM_LAT-1][1];
  assign fft_rvalid = pipe_q[MEM_LAT-1][2];
  assign rdata      = mem_rdata;

endmodule
